// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, x/y counters, registered sync/RGB
// outputs, frame counter and start-of-vblank interrupt behind a small device-bus register file.
module vga_timing_gen #(
    parameter int   CD        = 12,
    parameter int   DIV       = 2,
    parameter int   HD        = 640,
    parameter int   HF        = 16,
    parameter int   HR        = 96,
    parameter int   HB        = 48,
    parameter int   VD        = 480,
    parameter int   VF        = 10,
    parameter int   VR        = 2,
    parameter int   VB        = 33,
    parameter int   CNT_W     = 11,
    parameter logic HS_ACT    = 1'b0,
    parameter logic VS_ACT    = 1'b0,
    parameter int   AddrWidth = 32,
    parameter int   DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 device_req_i,
    input  logic [AddrWidth-1:0] device_addr_i,
    input  logic                 device_we_i,
    input  logic [3:0]           device_be_i,
    input  logic [DataWidth-1:0] device_wdata_i,
    output logic                 device_rvalid_o,
    output logic [DataWidth-1:0] device_rdata_o,
    output logic [CNT_W-1:0]     pix_x_o,
    output logic [CNT_W-1:0]     pix_y_o,
    input  logic [CD-1:0]        pix_rgb_i,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic [CD-1:0]        rgb_o,
    output logic                 irq_o
);
    localparam int HT    = HD + HF + HR + HB;
    localparam int VT    = VD + VF + VR + VB;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(VT - 1);
    localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(HD);
    localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(VD);
    localparam logic [CNT_W-1:0] Y_VLAST  = CNT_W'(VD - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(HD + HF);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(HD + HF + HR);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(VD + VF);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(VD + VF + VR);

    logic [2:0]           r_ctrl;
    logic [CD-1:0]        r_fill;
    logic [31:0]          r_frame;
    logic                 r_irq_pend;
    logic [DIV_W-1:0]     r_div;
    logic [CNT_W-1:0]     r_x;
    logic [CNT_W-1:0]     r_y;
    logic                 r_hsync;
    logic                 r_vsync;
    logic [CD-1:0]        r_rgb;
    logic                 r_rvalid;
    logic [DataWidth-1:0] r_rdata;

    logic                 w_en;
    logic                 w_tick;
    logic                 w_x_wrap;
    logic                 w_y_wrap;
    logic                 w_hs_act;
    logic                 w_vs_act;
    logic                 w_video_on;
    logic                 w_vblank;
    logic                 w_irq_set;
    logic [2:0]           w_sel;
    logic                 w_wr;
    logic                 w_w1c;
    logic [DataWidth-1:0] w_wmask;
    logic [2:0]           w_ctrl_new;
    logic [CD-1:0]        w_fill_new;
    logic [DataWidth-1:0] w_rdata;
    logic                 w_unused;

    assign w_en       = r_ctrl[0];
    assign w_tick     = w_en && (r_div == DIV_LAST);
    assign w_x_wrap   = (r_x == X_LAST);
    assign w_y_wrap   = (r_y == Y_LAST);
    assign w_hs_act   = (r_x >= HS_START) && (r_x < HS_END);
    assign w_vs_act   = (r_y >= VS_START) && (r_y < VS_END);
    assign w_video_on = (r_x < X_VIS) && (r_y < Y_VIS);
    assign w_vblank   = (r_y >= Y_VIS);
    // The tick that wraps x on the last visible line is the one that enters vblank.
    assign w_irq_set  = w_tick && w_x_wrap && (r_y == Y_VLAST);

    assign w_sel      = device_addr_i[4:2];
    assign w_wr       = device_req_i && device_we_i;
    assign w_w1c      = w_wr && (w_sel == 3'd1) && device_be_i[0] && device_wdata_i[1];
    assign w_ctrl_new = (r_ctrl & ~w_wmask[2:0]) | (device_wdata_i[2:0] & w_wmask[2:0]);
    assign w_fill_new = (r_fill & ~w_wmask[CD-1:0]) | (device_wdata_i[CD-1:0] & w_wmask[CD-1:0]);
    assign w_unused   = ^{device_addr_i[AddrWidth-1:5], device_addr_i[1:0], device_wdata_i, w_wmask};

    always_comb begin
        w_wmask = '0;
        for (int i = 0; i < 4; i++) begin
            w_wmask[8*i +: 8] = {8{device_be_i[i]}};
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            3'd0: w_rdata[2:0] = r_ctrl;
            3'd1: w_rdata[1:0] = {r_irq_pend, w_vblank};
            3'd2: begin
                w_rdata[16 +: CNT_W] = r_y;
                w_rdata[CNT_W-1:0]   = r_x;
            end
            3'd3: w_rdata[31:0] = r_frame;
            3'd4: w_rdata[CD-1:0] = r_fill;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ctrl <= '0;
            r_fill <= '0;
        end else begin
            if (w_wr && (w_sel == 3'd0)) r_ctrl <= w_ctrl_new;
            if (w_wr && (w_sel == 3'd4)) r_fill <= w_fill_new;
        end
    end

    // A set on the vblank-entry tick wins over a write-one-to-clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq_pend <= 1'b0;
            r_frame    <= '0;
        end else begin
            if (w_irq_set)  r_irq_pend <= 1'b1;
            else if (w_w1c) r_irq_pend <= 1'b0;
            if (w_tick && w_x_wrap && w_y_wrap) r_frame <= r_frame + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else if (!w_en) begin
            r_div <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
                if (w_x_wrap) begin
                    r_x <= '0;
                    r_y <= w_y_wrap ? '0 : r_y + CNT_W'(1);
                end else begin
                    r_x <= r_x + CNT_W'(1);
                end
            end
        end
    end

    // Outputs lag the counters by one clock; a disabled generator drives idle levels.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hsync <= ~HS_ACT;
            r_vsync <= ~VS_ACT;
            r_rgb   <= '0;
        end else if (!w_en) begin
            r_hsync <= ~HS_ACT;
            r_vsync <= ~VS_ACT;
            r_rgb   <= '0;
        end else begin
            r_hsync <= w_hs_act ? HS_ACT : ~HS_ACT;
            r_vsync <= w_vs_act ? VS_ACT : ~VS_ACT;
            r_rgb   <= w_video_on ? (r_ctrl[2] ? r_fill : pix_rgb_i) : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= device_req_i;
            r_rdata  <= (device_req_i && !device_we_i) ? w_rdata : '0;
        end
    end

    assign device_rvalid_o = r_rvalid;
    assign device_rdata_o  = r_rdata;
    assign pix_x_o         = r_x;
    assign pix_y_o         = r_y;
    assign hsync_o         = r_hsync;
    assign vsync_o         = r_vsync;
    assign rgb_o           = r_rgb;
    assign irq_o           = r_irq_pend & r_ctrl[1];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small 14x8 raster (DIV=2) plus a DIV=1 twin sharing the bus.
// Bus responses go through an expected-data queue; raster timing is measured in clocks.
module tb_vga_timing_gen;
    localparam int CD    = 12;
    localparam int CNT_W = 5;
    localparam logic [31:0] A_CTRL  = 32'h00;
    localparam logic [31:0] A_STAT  = 32'h04;
    localparam logic [31:0] A_POS   = 32'h08;
    localparam logic [31:0] A_FRAME = 32'h0C;
    localparam logic [31:0] A_FILL  = 32'h10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0;
    logic [31:0]      addr = '0;
    logic             we = 1'b0;
    logic [3:0]       be = '0;
    logic [31:0]      wdata = '0;
    logic             rvalid0, rvalid1;
    logic [31:0]      rdata0, rdata1;
    logic [CNT_W-1:0] x0, y0, x1, y1;
    logic [CD-1:0]    pix_rgb;
    logic [CD-1:0]    rgb0, rgb1;
    logic             hs0, vs0, irq0, hs1, vs1, irq1;

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [CD-1:0] pix_fn(input logic [CNT_W-1:0] px, input logic [CNT_W-1:0] py);
        return {py[3:0], px[3:0], 4'h9};
    endfunction

    assign pix_rgb = pix_fn(x0, y0);

    vga_timing_gen #(
        .CD(CD), .DIV(2), .HD(8), .HF(2), .HR(2), .HB(2), .VD(4), .VF(1), .VR(2), .VB(1),
        .CNT_W(CNT_W), .HS_ACT(1'b0), .VS_ACT(1'b1), .AddrWidth(32), .DataWidth(32)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .device_req_i(req), .device_addr_i(addr),
        .device_we_i(we), .device_be_i(be), .device_wdata_i(wdata),
        .device_rvalid_o(rvalid0), .device_rdata_o(rdata0),
        .pix_x_o(x0), .pix_y_o(y0), .pix_rgb_i(pix_rgb),
        .hsync_o(hs0), .vsync_o(vs0), .rgb_o(rgb0), .irq_o(irq0)
    );

    vga_timing_gen #(
        .CD(CD), .DIV(1), .HD(8), .HF(2), .HR(2), .HB(2), .VD(4), .VF(1), .VR(2), .VB(1),
        .CNT_W(CNT_W), .HS_ACT(1'b0), .VS_ACT(1'b1), .AddrWidth(32), .DataWidth(32)
    ) u_dut_div1 (
        .clk_i(clk), .rst_ni(rst_n), .device_req_i(req), .device_addr_i(addr),
        .device_we_i(we), .device_be_i(be), .device_wdata_i(wdata),
        .device_rvalid_o(rvalid1), .device_rdata_o(rdata1),
        .pix_x_o(x1), .pix_y_o(y1), .pix_rgb_i(12'h000),
        .hsync_o(hs1), .vsync_o(vs1), .rgb_o(rgb1), .irq_o(irq1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Request is one cycle long; rvalid/rdata arrive one cycle later (write data reads as 0).
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
        exp_q.push_back(32'h0);
        name_q.push_back("wr_rdata");
        @(negedge clk);
        req = 1'b0; we = 1'b0; be = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        req = 1'b0; be = '0;
    endtask

    // which: 0 hsync, 1 hsync of DIV=1 twin, 2 vsync, 3 irq. n = clocks until level seen, -1 on timeout.
    task automatic wait_level(input int which, input logic lvl, input int budget, output int n);
        logic s;
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            case (which)
                0:       s = hs0;
                1:       s = hs1;
                2:       s = vs0;
                default: s = irq0;
            endcase
            if (s == lvl) begin
                n = i;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rvalid0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                check(name_q.pop_front(), rdata0, exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, e0, frames_exp, cnt_fill, cnt_other, mism, vis;
        logic [CNT_W-1:0] px, py;
        logic [CD-1:0] exp_rgb;

        repeat (3) @(negedge clk);
        check("rst_hsync", {31'b0, hs0}, 32'd1);
        check("rst_vsync", {31'b0, vs0}, 32'd0);
        check("rst_rgb", {20'b0, rgb0}, 32'd0);
        check("rst_irq", {31'b0, irq0}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid0}, 32'd0);
        check("rst_pos", {11'b0, y0, 11'b0, x0}, 32'd0);
        rst_n = 1'b1;

        bus_read(A_CTRL, 32'h0, "ctrl_reset");
        bus_read(A_STAT, 32'h0, "stat_reset");
        bus_read(A_POS, 32'h0, "pos_reset");
        bus_read(A_FRAME, 32'h0, "frame_reset");
        bus_read(A_FILL, 32'h0, "fill_reset");
        bus_read(32'h14, 32'h0, "unmapped_read");
        bus_write(A_FILL, 32'hFFFF_FABC, 4'hF);
        bus_read(A_FILL, 32'hABC, "fill_full_write");
        bus_write(A_FILL, 32'h0000_00FF, 4'b0001);
        bus_read(A_FILL, 32'hAFF, "fill_byte_enable");
        bus_read(32'h30, 32'hAFF, "addr_alias_fill");
        bus_write(A_CTRL, 32'h7, 4'b0000);
        bus_read(A_CTRL, 32'h0, "ctrl_no_be");
        bus_write(A_FILL, 32'hABC, 4'hF);
        bus_write(32'h1C, 32'hFFFF, 4'hF);
        bus_read(A_FILL, 32'hABC, "unmapped_write_ignored");
        bus_write(A_STAT, 32'h1, 4'hF);
        bus_read(A_STAT, 32'h0, "stat_ro");

        bus_write(A_CTRL, 32'h1, 4'hF);
        e0 = cyc;
        wait_level(0, 1'b0, 100, n);
        check("hs_first_edge", n, 21);
        wait_level(0, 1'b1, 100, n);
        check("hs_width", n, 4);
        wait_level(0, 1'b0, 100, n);
        check("hs_period", n + 4, 28);

        wait_level(1, 1'b1, 50, n);
        wait_level(1, 1'b0, 50, n);
        wait_level(1, 1'b1, 50, n);
        check("hs_width_div1", n, 2);
        wait_level(1, 1'b0, 50, n);
        check("hs_period_div1", n + 2, 14);

        wait_level(2, 1'b0, 300, n);
        wait_level(2, 1'b1, 300, n);
        wait_level(2, 1'b0, 300, n);
        check("vs_width", n, 56);
        wait_level(2, 1'b1, 300, n);
        check("vs_period", n + 56, 224);

        while (cyc - e0 < 458) @(negedge clk);
        bus_read(A_FRAME, 32'd2, "frame_after_two");

        bus_write(A_CTRL, 32'h3, 4'hF);
        check("irq_pend_enabled", {31'b0, irq0}, 32'd1);
        bus_write(A_STAT, 32'h2, 4'hF);
        check("irq_w1c", {31'b0, irq0}, 32'd0);
        wait_level(3, 1'b1, 300, n);
        check("irq_rise_y", {27'b0, y0}, 32'd4);
        check("irq_rise_x", {27'b0, x0}, 32'd0);
        bus_read(A_STAT, 32'h3, "stat_vblank_pend");
        bus_write(A_STAT, 32'h2, 4'hF);
        check("irq_w1c_again", {31'b0, irq0}, 32'd0);
        while (((cyc - e0) % 224) != 110) @(negedge clk);
        check("irq_before_collision", {31'b0, irq0}, 32'd0);
        bus_write(A_STAT, 32'h2, 4'hF);
        check("irq_set_wins", {31'b0, irq0}, 32'd1);
        bus_write(A_CTRL, 32'h1, 4'hF);
        check("irq_masked", {31'b0, irq0}, 32'd0);
        bus_read(A_STAT, 32'h3, "stat_pend_masked");

        bus_write(A_CTRL, 32'h5, 4'hF);
        cnt_fill = 0;
        cnt_other = 0;
        for (int i = 0; i < 224; i++) begin
            @(posedge clk);
            #1;
            if (rgb0 == 12'hABC) cnt_fill++;
            else if (rgb0 != 12'h000) cnt_other++;
        end
        check("fill_pixels", cnt_fill, 64);
        check("fill_blank_zero", cnt_other, 0);

        bus_write(A_CTRL, 32'h1, 4'hF);
        px = x0;
        py = y0;
        mism = 0;
        vis = 0;
        for (int i = 0; i < 224; i++) begin
            @(posedge clk);
            #1;
            exp_rgb = ((px < 8) && (py < 4)) ? pix_fn(px, py) : 12'h000;
            if ((px < 8) && (py < 4)) vis++;
            if (rgb0 !== exp_rgb) mism++;
            px = x0;
            py = y0;
        end
        check("src_follow_mismatches", mism, 0);
        check("src_visible_count", vis, 64);

        n = 0;
        while (!((x0 == 5'd4) && (y0 < 5'd4)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        bus_write(A_CTRL, 32'h0, 4'hF);
        frames_exp = (cyc - e0) / 224;
        @(negedge clk);
        check("dis_pos", {11'b0, y0, 11'b0, x0}, 32'd0);
        check("dis_hsync", {31'b0, hs0}, 32'd1);
        check("dis_vsync", {31'b0, vs0}, 32'd0);
        check("dis_rgb", {20'b0, rgb0}, 32'd0);
        bus_read(A_FRAME, frames_exp, "frame_at_disable");
        repeat (40) @(negedge clk);
        check("dis_x_held", {27'b0, x0}, 32'd0);
        bus_read(A_FRAME, frames_exp, "frame_retained");
        bus_read(A_FILL, 32'hABC, "fill_retained");

        bus_write(A_CTRL, 32'h3, 4'hF);
        check("pend_retained", {31'b0, irq0}, 32'd1);
        wait_level(0, 1'b0, 100, n);
        check("hs_first_restart", n, 21);

        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_hsync", {31'b0, hs0}, 32'd1);
        check("arst_vsync", {31'b0, vs0}, 32'd0);
        check("arst_rgb", {20'b0, rgb0}, 32'd0);
        check("arst_irq", {31'b0, irq0}, 32'd0);
        check("arst_rvalid", {31'b0, rvalid0}, 32'd0);
        check("arst_rdata", rdata0, 32'd0);
        check("arst_pos", {11'b0, y0, 11'b0, x0}, 32'd0);
        check("arst_hsync_div1", {31'b0, hs1}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(A_CTRL, 32'h0, "ctrl_after_arst");
        bus_read(A_FRAME, 32'h0, "frame_after_arst");
        bus_read(A_FILL, 32'h0, "fill_after_arst");
        bus_read(A_STAT, 32'h0, "stat_after_arst");

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
